control_sequencer: RTL

//  Hard-wired control unit directly upstream of Datapath; generates every per-T-state control strobe Datapath consumes.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/ir_decoder.sv | 26 ++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the control sequencer: opcodes, IR field positions, state and instruction class.
package cpu_pkg;

    localparam int OP_W      = 5;
    localparam int REG_W     = 4;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00010;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00011;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00100;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        IC_NOP,
        IC_BIN,
        IC_UNARY,
        IC_MULDIV,
        IC_HALT
    } iclass_t;

    function automatic iclass_t op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return IC_BIN;
            OP_NEG, OP_NOT:                 return IC_UNARY;
            OP_MUL, OP_DIV:                 return IC_MULDIV;
            OP_HALT:                        return IC_HALT;
            default:                        return IC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ir_decoder.sv
// Combinational IR decode: instruction class, raw opcode and one-hot Ra/Rb/Rc selects.
module ir_decoder
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16
)(
    input  logic [31:0]         ir,
    output iclass_t             iclass,
    output logic [OP_W-1:0]     op,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh
);

    logic unused_ir_low;

    // The low 15 IR bits carry no meaning for R-format instructions.
    assign unused_ir_low = ^ir[IR_RC_LSB-1:0];

    assign op     = ir[IR_OP_LSB +: OP_W];
    assign iclass = op_class(op);
    assign ra_oh  = NUM_REGS'(1) << ir[IR_RA_LSB +: REG_W];
    assign rb_oh  = NUM_REGS'(1) << ir[IR_RB_LSB +: REG_W];
    assign rc_oh  = NUM_REGS'(1) << ir[IR_RC_LSB +: REG_W];

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired T-state sequencer producing every Datapath control strobe as a Moore decode of its state.
// Defining CTRL_STEP_EN adds a step input: each active state is held until step is high at a clock edge.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
)(
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
`ifdef CTRL_STEP_EN
    input  logic                step,
`endif
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPW-1:0]      opcode,
    output logic                halted
);

    state_t              state, state_nxt;
    iclass_t             cls_q, dec_cls;
    logic [OP_W-1:0]     dec_op;
    logic [NUM_REGS-1:0] dec_ra, dec_rb, dec_rc;
    logic [NUM_REGS-1:0] ra_q, rb_q, rc_q;
    logic                adv;

`ifdef CTRL_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    ir_decoder #(.NUM_REGS(NUM_REGS)) u_ir_decoder (
        .ir     (ir),
        .iclass (dec_cls),
        .op     (dec_op),
        .ra_oh  (dec_ra),
        .rb_oh  (dec_rb),
        .rc_oh  (dec_rc)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= ST_IDLE;
            cls_q  <= IC_NOP;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            opcode <= '0;
        end else begin
            state <= state_nxt;
            // IR is captured once per instruction so later IR changes cannot disturb execute.
            if (state == ST_T2 && state_nxt == ST_T3) begin
                cls_q  <= dec_cls;
                ra_q   <= dec_ra;
                rb_q   <= dec_rb;
                rc_q   <= dec_rc;
                opcode <= OPW'(dec_op);
            end else if (state_nxt == ST_IDLE) begin
                opcode <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (run && adv) state_nxt = ST_T0;
            ST_T0:   if (adv) state_nxt = ST_T1;
            ST_T1:   if (adv) state_nxt = ST_T2;
            ST_T2:   if (adv) state_nxt = ST_T3;
            ST_T3:   if (adv) state_nxt = (cls_q == IC_HALT) ? ST_HALT : ST_T4;
            ST_T4:   if (adv) state_nxt = ST_T5;
            ST_T5:   if (adv) state_nxt = (cls_q == IC_MULDIV) ? ST_T6 :
                                          (run ? ST_T0 : ST_IDLE);
            ST_T6:   if (adv) state_nxt = run ? ST_T0 : ST_IDLE;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rout     = '0;
        Rin      = '0;
        halted   = (state == ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (cls_q == IC_BIN) begin
                    Rout = rb_q;
                    Yin  = 1'b1;
                end else if (cls_q == IC_MULDIV) begin
                    Rout = ra_q;
                    Yin  = 1'b1;
                end
            end
            ST_T4: begin
                if (cls_q == IC_BIN) begin
                    Rout = rc_q;
                    Zin  = 1'b1;
                end else if (cls_q == IC_UNARY || cls_q == IC_MULDIV) begin
                    Rout = rb_q;
                    Zin  = 1'b1;
                end
            end
            ST_T5: begin
                if (cls_q == IC_BIN || cls_q == IC_UNARY) begin
                    Zlowout = 1'b1;
                    Rin     = ra_q;
                end else if (cls_q == IC_MULDIV) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
